// File: rtl/xnor_frame_comparator.sv
// rtl/xnor_frame_comparator.sv - framed bitwise XNOR comparator with match counting
//
// Compares two WIDTH-bit words bit by bit (XNOR: 1 where bits are equal) and
// accumulates the number of equal bits over a frame of FRAME_LEN accepted
// words. At the end of the frame it pulses done for one cycle and reports
// whether every compared bit matched.
//
// Optional build macro: XNOR_FRAME_MASK_EN
//   When defined, a mask input selects which bits are counted. The frame is
//   "all equal" when every masked-in bit matched.
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   synchronous active-high reset
//   start       in   begin a frame (sampled in IDLE only)
//   in_valid    in   a/b pair valid (sampled in RUN only)
//   a, b        in   WIDTH-bit operand words
//   mask        in   WIDTH-bit count mask (XNOR_FRAME_MASK_EN builds only)
//   s           out  registered XNOR of the last accepted pair
//   match_count out  running / final count of equal bits in the frame
//   all_equal   out  final count reached the frame target
//   busy        out  high while accepting words
//   done        out  one-cycle pulse at the end of a frame

module xnor_frame_comparator #(
  parameter  int WIDTH     = 4,
  parameter  int FRAME_LEN = 4,
  localparam int CW        = $clog2(WIDTH*FRAME_LEN+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef XNOR_FRAME_MASK_EN
  input  logic [WIDTH-1:0] mask,
`endif
  output logic [WIDTH-1:0] s,
  output logic [CW-1:0]    match_count,
  output logic             all_equal,
  output logic             busy,
  output logic             done
);

  // Word counter sized so FRAME_LEN=1 still gets a 1-bit counter.
  localparam int              WCW       = $clog2(FRAME_LEN+1);
  localparam logic [WCW-1:0]  LAST_WORD = WCW'(FRAME_LEN-1);
  localparam logic [CW-1:0]   MAX_COUNT = CW'(WIDTH*FRAME_LEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [CW-1:0]    match_q, match_d;
  logic             all_equal_q, all_equal_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WCW-1:0]   word_q, word_d;

  logic [WIDTH-1:0] xnor_w;
  logic [WIDTH-1:0] counted_w;
  logic [CW-1:0]    target_w;

  function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      c = c + CW'(v[i]);
    end
    return c;
  endfunction

  assign xnor_w = ~(a ^ b);

`ifdef XNOR_FRAME_MASK_EN
  logic [CW-1:0] mask_cnt_q, mask_cnt_d;

  assign counted_w = xnor_w & mask;
  // The frame target is however many bits the mask let through this frame.
  assign target_w  = mask_cnt_d;
`else
  assign counted_w = xnor_w;
  assign target_w  = MAX_COUNT;
`endif

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    match_d     = match_q;
    all_equal_d = all_equal_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    word_d      = word_q;
`ifdef XNOR_FRAME_MASK_EN
    mask_cnt_d  = mask_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = RUN;
          busy_d      = 1'b1;
          s_d         = '0;
          match_d     = '0;
          all_equal_d = 1'b0;
          word_d      = '0;
`ifdef XNOR_FRAME_MASK_EN
          mask_cnt_d  = '0;
`endif
        end
      end

      RUN: begin
        if (in_valid) begin
          s_d     = xnor_w;
          match_d = match_q + popcount(counted_w);
`ifdef XNOR_FRAME_MASK_EN
          mask_cnt_d = mask_cnt_q + popcount(mask);
`endif
          if (word_q == LAST_WORD) begin
            // Final word: flag is computed from the final count so it is
            // valid in the same cycle as done.
            state_d     = DONE;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            all_equal_d = (match_d == target_w);
            word_d      = '0;
          end else begin
            word_d = word_q + 1'b1;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      s_q         <= '0;
      match_q     <= '0;
      all_equal_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      word_q      <= '0;
`ifdef XNOR_FRAME_MASK_EN
      mask_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      match_q     <= match_d;
      all_equal_q <= all_equal_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      word_q      <= word_d;
`ifdef XNOR_FRAME_MASK_EN
      mask_cnt_q  <= mask_cnt_d;
`endif
    end
  end

  assign s           = s_q;
  assign match_count = match_q;
  assign all_equal   = all_equal_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_xnor_frame_comparator.sv
// tb/tb_xnor_frame_comparator.sv - directed self-checking bench for xnor_frame_comparator

module tb_xnor_frame_comparator;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] s;
  logic [4:0] match_count;
  logic       all_equal;
  logic       busy;
  logic       done;

  // Second instance for the single-word frame boundary.
  logic       start1;
  logic       valid1;
  logic [3:0] a1;
  logic [3:0] b1;
  logic [3:0] s1;
  logic [2:0] match_count1;
  logic       all_equal1;
  logic       busy1;
  logic       done1;

`ifdef XNOR_FRAME_MASK_EN
  logic [3:0] mask;
  logic [3:0] mask1;
`endif

  int n_checks = 0;
  int n_errors = 0;

  xnor_frame_comparator #(.WIDTH(4), .FRAME_LEN(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .in_valid    (in_valid),
    .a           (a),
    .b           (b),
`ifdef XNOR_FRAME_MASK_EN
    .mask        (mask),
`endif
    .s           (s),
    .match_count (match_count),
    .all_equal   (all_equal),
    .busy        (busy),
    .done        (done)
  );

  xnor_frame_comparator #(.WIDTH(4), .FRAME_LEN(1)) dut1 (
    .clk         (clk),
    .reset       (reset),
    .start       (start1),
    .in_valid    (valid1),
    .a           (a1),
    .b           (b1),
`ifdef XNOR_FRAME_MASK_EN
    .mask        (mask1),
`endif
    .s           (s1),
    .match_count (match_count1),
    .all_equal   (all_equal1),
    .busy        (busy1),
    .done        (done1)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] e_s, input logic [4:0] e_mc,
                            input logic e_busy, input logic e_done, input logic e_ae);
    check_val({tag, ".s"},           32'(s),           32'(e_s));
    check_val({tag, ".match_count"}, 32'(match_count), 32'(e_mc));
    check_val({tag, ".busy"},        32'(busy),        32'(e_busy));
    check_val({tag, ".done"},        32'(done),        32'(e_done));
    check_val({tag, ".all_equal"},   32'(all_equal),   32'(e_ae));
  endtask

  initial begin
    reset    = 1'b1;
    start    = $urandom_range(0, 1);
    in_valid = $urandom_range(0, 1);
    a        = 4'($urandom);
    b        = 4'($urandom);
    start1   = 1'b0;
    valid1   = 1'b0;
    a1       = 4'h0;
    b1       = 4'h0;
`ifdef XNOR_FRAME_MASK_EN
    mask     = 4'hF;
    mask1    = 4'hF;
`endif

    // Reset held two cycles with random inputs
    tick();
    start = $urandom_range(0, 1);
    a     = 4'($urandom);
    tick();
    expect_out("rst", 4'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;

    // Frame of identical words; start in DONE must be ignored
    start = 1'b1;
    tick();
    expect_out("eq.start", 4'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    start    = 1'b0;
    in_valid = 1'b1;
    a        = 4'b1010;
    b        = 4'b1010;
    tick(); expect_out("eq.w0", 4'hF, 5'd4,  1'b1, 1'b0, 1'b0);
    tick(); expect_out("eq.w1", 4'hF, 5'd8,  1'b1, 1'b0, 1'b0);
    tick(); expect_out("eq.w2", 4'hF, 5'd12, 1'b1, 1'b0, 1'b0);
    tick(); expect_out("eq.w3", 4'hF, 5'd16, 1'b0, 1'b1, 1'b1);
    in_valid = 1'b0;
    start    = 1'b1;
    tick(); expect_out("eq.idle", 4'hF, 5'd16, 1'b0, 1'b0, 1'b1);
    start = 1'b0;
    tick(); expect_out("eq.hold", 4'hF, 5'd16, 1'b0, 1'b0, 1'b1);

    // Frame of fully different words
    start = 1'b1;
    tick();
    expect_out("ne.start", 4'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    start    = 1'b0;
    in_valid = 1'b1;
    a        = 4'b0000;
    b        = 4'b1111;
    tick(); expect_out("ne.w0", 4'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick(); expect_out("ne.w1", 4'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick(); expect_out("ne.w2", 4'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick(); expect_out("ne.w3", 4'h0, 5'd0, 1'b0, 1'b1, 1'b0);
    in_valid = 1'b0;
    tick(); expect_out("ne.idle", 4'h0, 5'd0, 1'b0, 1'b0, 1'b0);

    // Mixed words with gaps
    start = 1'b1;
    tick();
    start    = 1'b0;
    in_valid = 1'b1; a = 4'b1100; b = 4'b1010;
    tick(); expect_out("gap.w0", 4'b1001, 5'd2, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b0; a = 4'b0000; b = 4'b0000;
    tick(); expect_out("gap.g0", 4'b1001, 5'd2, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b1; a = 4'b1111; b = 4'b1111;
    tick(); expect_out("gap.w1", 4'b1111, 5'd6, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); expect_out("gap.g1", 4'b1111, 5'd6, 1'b1, 1'b0, 1'b0);
    end
    in_valid = 1'b1; a = 4'b0000; b = 4'b0001;
    tick(); expect_out("gap.w2", 4'b1110, 5'd9, 1'b1, 1'b0, 1'b0);
    a = 4'b0110; b = 4'b0110;
    tick(); expect_out("gap.w3", 4'b1111, 5'd13, 1'b0, 1'b1, 1'b0);
    in_valid = 1'b0;
    tick(); expect_out("gap.idle", 4'b1111, 5'd13, 1'b0, 1'b0, 1'b0);

    // Reset mid-frame aborts without done
    start = 1'b1;
    tick();
    start    = 1'b0;
    in_valid = 1'b1; a = 4'b1111; b = 4'b1111;
    tick();
    tick(); expect_out("abort.pre", 4'hF, 5'd8, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    tick(); expect_out("abort.rst", 4'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    // in_valid stays high in IDLE and must not be counted
    tick(); expect_out("idle.v0", 4'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick(); expect_out("idle.v1", 4'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    tick(); expect_out("re.start", 4'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    start = 1'b0; a = 4'b0011; b = 4'b0001;
    tick(); expect_out("re.w0", 4'b1101, 5'd3,  1'b1, 1'b0, 1'b0);
    tick(); expect_out("re.w1", 4'b1101, 5'd6,  1'b1, 1'b0, 1'b0);
    tick(); expect_out("re.w2", 4'b1101, 5'd9,  1'b1, 1'b0, 1'b0);
    tick(); expect_out("re.w3", 4'b1101, 5'd12, 1'b0, 1'b1, 1'b0);
    in_valid = 1'b0;
    tick();

    // Single-word frame goes straight to DONE
    start1 = 1'b1;
    tick();
    check_val("f1.busy", 32'(busy1), 32'd1);
    start1 = 1'b0; valid1 = 1'b1; a1 = 4'b1010; b1 = 4'b1011;
    tick();
    check_val("f1.done",  32'(done1),        32'd1);
    check_val("f1.count", 32'(match_count1), 32'd3);
    check_val("f1.s",     32'(s1),           32'b1110);
    check_val("f1.ae",    32'(all_equal1),   32'd0);
    check_val("f1.busy2", 32'(busy1),        32'd0);
    valid1 = 1'b0;
    tick();
    check_val("f1.done2", 32'(done1), 32'd0);

`ifdef XNOR_FRAME_MASK_EN
    // xnor(1001,0101) = 0011; masked counts drive the target
    start = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b1; a = 4'b1001; b = 4'b0101; mask = 4'b0111;
    repeat (4) tick();
    expect_out("m0111", 4'b0011, 5'd8, 1'b0, 1'b1, 1'b0);
    in_valid = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b1; mask = 4'b0001;
    repeat (4) tick();
    expect_out("m0001", 4'b0011, 5'd4, 1'b0, 1'b1, 1'b1);
    in_valid = 1'b0;
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
